// File: rtl/btn_debounce.sv
// btn_debounce
//   Per-channel push-button debouncer. Each raw pin is brought into the
//   clk_lb domain through a two-flop synchronizer. A small FSM then accepts a
//   new level only after the synchronized value has been seen at that level
//   on DEB_CYCLES consecutive clock edges. Any return to the old level before
//   that point cancels the attempt and leaves the output unchanged.
//
// Parameters
//   N_BTN      : number of independent button channels (1..16)
//   CNT_W      : width of each per-channel debounce counter
//   DEB_CYCLES : consecutive stable samples needed to accept a level
//                (2 .. 2**CNT_W-1)
//
// Ports
//   clk_lb   : clock; all state changes on its rising edge
//   reset_n  : asynchronous, active-low reset
//   btn_in   : raw asynchronous button pins, 1 = pressed
//   btn_lvl  : registered debounced level per channel
//   btn_rise : registered one-cycle pulse when btn_lvl goes 0->1
//   btn_fall : registered one-cycle pulse when btn_lvl goes 1->0
module btn_debounce #(
  parameter int N_BTN      = 5,
  parameter int CNT_W      = 20,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk_lb,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
);

  typedef enum logic [1:0] {
    LO_STABLE,
    HI_WAIT,
    HI_STABLE,
    LO_WAIT
  } state_t;

  // Counter value on the edge that completes DEB_CYCLES stable samples.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_BTN-1:0] btn_meta;
  logic [N_BTN-1:0] btn_sync;
  state_t           state [N_BTN];
  logic [CNT_W-1:0] cnt   [N_BTN];

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
    end
  end

  // The counter holds the number of consecutive samples already seen at the
  // candidate level, so entering a WAIT state loads 1 (this edge counts) and
  // acceptance happens when the current sample would make it DEB_CYCLES.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state[i] <= LO_STABLE;
        cnt[i]   <= '0;
      end
      btn_lvl  <= '0;
      btn_rise <= '0;
      btn_fall <= '0;
    end else begin
      btn_rise <= '0;
      btn_fall <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        case (state[i])
          LO_STABLE: begin
            if (btn_sync[i]) begin
              state[i] <= HI_WAIT;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i]   <= '0;
            end
          end
          HI_WAIT: begin
            if (!btn_sync[i]) begin
              state[i] <= LO_STABLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i]    <= HI_STABLE;
              cnt[i]      <= '0;
              btn_lvl[i]  <= 1'b1;
              btn_rise[i] <= 1'b1;
            end else begin
              cnt[i]   <= cnt[i] + CNT_W'(1);
            end
          end
          HI_STABLE: begin
            if (!btn_sync[i]) begin
              state[i] <= LO_WAIT;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i]   <= '0;
            end
          end
          LO_WAIT: begin
            if (btn_sync[i]) begin
              state[i] <= HI_STABLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i]    <= LO_STABLE;
              cnt[i]      <= '0;
              btn_lvl[i]  <= 1'b0;
              btn_fall[i] <= 1'b1;
            end else begin
              cnt[i]   <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= LO_STABLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce
//   Directed-stimulus bench for btn_debounce (N_BTN=5, DEB_CYCLES=4).
//   A reference model derives expected outputs from the acceptance rule:
//   each pin reaches the debouncer two edges late, and a channel's level
//   flips once the delayed pin has differed from it on DEB_CYCLES
//   consecutive edges. Directed checks with literal values pin the timing.
module tb_btn_debounce;

  localparam int N   = 5;
  localparam int DEB = 4;

  logic         clk_lb;
  logic         reset_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_lvl;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;

  int n_cmp = 0;
  int n_bad = 0;

  btn_debounce #(
    .N_BTN     (N),
    .CNT_W     (8),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk_lb  (clk_lb),
    .reset_n (reset_n),
    .btn_in  (btn_in),
    .btn_lvl (btn_lvl),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );

  initial clk_lb = 1'b0;
  always #5 clk_lb = ~clk_lb;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic [N-1:0] h1, h2, s;
  logic [N-1:0] e_lvl, e_rise, e_fall;
  int           run [N];

  initial begin
    h1 = '0; h2 = '0; e_lvl = '0; e_rise = '0; e_fall = '0;
    for (int c = 0; c < N; c++) run[c] = 0;
    forever begin
      @(posedge clk_lb);
      e_rise = '0;
      e_fall = '0;
      if (!reset_n) begin
        h1 = '0; h2 = '0; e_lvl = '0;
        for (int c = 0; c < N; c++) run[c] = 0;
      end else begin
        s  = h2;
        h2 = h1;
        h1 = btn_in;
        for (int c = 0; c < N; c++) begin
          if (s[c] != e_lvl[c]) begin
            run[c]++;
            if (run[c] == DEB) begin
              e_lvl[c] = s[c];
              if (s[c]) e_rise[c] = 1'b1;
              else      e_fall[c] = 1'b1;
              run[c] = 0;
            end
          end else begin
            run[c] = 0;
          end
        end
      end
      #1;
      chk("model_lvl",  16'(btn_lvl),  16'(e_lvl));
      chk("model_rise", 16'(btn_rise), 16'(e_rise));
      chk("model_fall", 16'(btn_fall), 16'(e_fall));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_lb);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    btn_in  = '0;
    step(3);
    chk("reset_lvl",  16'(btn_lvl),  16'h0);
    chk("reset_rise", 16'(btn_rise), 16'h0);
    chk("reset_fall", 16'(btn_fall), 16'h0);
    @(negedge clk_lb) reset_n = 1'b1;
    step(3);

    // Clean press on channel 0
    btn_in = 5'b00001;
    step(5);
    chk("press_lvl_early",  16'(btn_lvl),  16'h0);
    chk("press_rise_early", 16'(btn_rise), 16'h0);
    step(1);
    chk("press_lvl",  16'(btn_lvl),  16'h01);
    chk("press_rise", 16'(btn_rise), 16'h01);
    step(1);
    chk("press_rise_1cyc", 16'(btn_rise), 16'h0);

    // Glitch on channel 1: high for 3 clocks only
    btn_in[1] = 1'b1;
    step(3);
    btn_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("glitch_lvl",  16'(btn_lvl[1]),  16'h0);
      chk("glitch_rise", 16'(btn_rise[1]), 16'h0);
      chk("glitch_fall", 16'(btn_fall[1]), 16'h0);
    end

    // Bounce then settle on channel 2
    btn_in[2] = 1'b1; step(1);
    btn_in[2] = 1'b0; step(1);
    btn_in[2] = 1'b1; step(1);
    btn_in[2] = 1'b0; step(1);
    btn_in[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("bounce_no_rise", 16'(btn_rise[2]), 16'h0);
    end
    step(1);
    chk("bounce_rise", 16'(btn_rise[2]), 16'h1);
    chk("bounce_lvl",  16'(btn_lvl[2]),  16'h1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("bounce_single", 16'(btn_rise[2]), 16'h0);
    end

    // Release on channel 3
    btn_in[3] = 1'b1;
    step(8);
    chk("rel_pre_lvl", 16'(btn_lvl[3]), 16'h1);
    btn_in[3] = 1'b0;
    step(5);
    chk("rel_lvl_early", 16'(btn_lvl[3]), 16'h1);
    step(1);
    chk("rel_lvl",  16'(btn_lvl[3]),  16'h0);
    chk("rel_fall", 16'(btn_fall[3]), 16'h1);
    step(1);
    chk("rel_fall_1cyc", 16'(btn_fall[3]), 16'h0);

    // Simultaneous press
    btn_in = '0;
    step(10);
    chk("idle_lvl", 16'(btn_lvl), 16'h0);
    btn_in = 5'b10101;
    step(5);
    chk("simul_rise_early", 16'(btn_rise), 16'h0);
    step(1);
    chk("simul_rise", 16'(btn_rise), 16'h15);
    chk("simul_lvl",  16'(btn_lvl),  16'h15);
    step(1);
    chk("simul_rise_1cyc", 16'(btn_rise), 16'h0);

    // Reset mid-count on channel 4
    btn_in = '0;
    step(10);
    btn_in = 5'b10000;
    step(4);
    @(negedge clk_lb) reset_n = 1'b0;
    step(3);
    chk("rst_mid_lvl",  16'(btn_lvl),  16'h0);
    chk("rst_mid_rise", 16'(btn_rise), 16'h0);
    @(negedge clk_lb) reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("rst_no_rise", 16'(btn_rise), 16'h0);
    end
    step(1);
    chk("rst_rise", 16'(btn_rise), 16'h10);
    chk("rst_lvl",  16'(btn_lvl),  16'h10);
    step(1);
    chk("rst_rise_1cyc", 16'(btn_rise), 16'h0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
